// File: rtl/boot_pkg.sv
// Shared state encoding, default sizes and word-assembly helper for the EEPROM boot loader.
package boot_pkg;

  localparam int NUM_BYTES_DEF      = 256;
  localparam int TIMEOUT_CYCLES_DEF = 65535;
  localparam int TIMEOUT_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    DONE,
    ERROR
  } boot_state_t;

  // Little-endian lane insert: lane 0 lands in bits 7:0.
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  data);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0: r[7:0]   = data;
      2'd1: r[15:8]  = data;
      2'd2: r[23:16] = data;
      default: r[31:24] = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/boot_timeout.sv
// Per-byte read-ack watchdog: counts enabled cycles, flags the LIMIT-th one combinationally.
// No handshake; clear has priority over enable.
module boot_timeout
  import boot_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(LIMIT - 1);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/eeprom_boot_loader.sv
// Copies NUM_BYTES from the EEPROM into instruction memory as 32-bit words; one request per byte.
// Optional image checksum (sum of all bytes must be 0x00) under macro BOOT_CHECKSUM_EN.
module eeprom_boot_loader
  import boot_pkg::*;
#(
  parameter int NUM_BYTES      = NUM_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_start,
  output logic        rd_req,
  output logic [7:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic        imem_we,
  output logic [5:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        boot_complete,
  output logic        boot_error
);

  localparam logic [8:0] LAST_CNT = 9'(NUM_BYTES);

  boot_state_t state;
  logic [8:0]  byte_cnt;
  logic [31:0] word_buf;
  logic [31:0] next_word;
  logic        to_clear;
  logic        to_en;
  logic        to_expired;
  logic        sum_ok;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum;
  assign sum_ok = (csum == 8'h00);
`else
  assign sum_ok = 1'b1;
`endif

  assign next_word = put_lane(word_buf, byte_cnt[1:0], rd_data);

  // The watchdog only runs while a request is outstanding; an ack in the expiry cycle disables it.
  assign to_clear = !((state == REQ) && rd_req);
  assign to_en    = (state == REQ) && rd_req && !rd_ack;

  boot_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (to_clear),
    .enable (to_en),
    .expired(to_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      word_buf      <= '0;
      rd_req        <= 1'b0;
      rd_addr       <= '0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      boot_complete <= 1'b0;
      boot_error    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (boot_start) begin
            state         <= REQ;
            byte_cnt      <= '0;
            word_buf      <= '0;
            boot_complete <= 1'b0;
            boot_error    <= 1'b0;
            rd_req        <= 1'b1;
            rd_addr       <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end
        REQ: begin
          if (rd_req) begin
            if (rd_ack) begin
              word_buf <= next_word;
              byte_cnt <= byte_cnt + 9'd1;
              rd_req   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
              csum     <= csum + rd_data;
`endif
              if (byte_cnt[1:0] == 2'd3) begin
                state      <= WRITE;
                imem_we    <= 1'b1;
                imem_addr  <= byte_cnt[7:2];
                imem_wdata <= next_word;
              end
            end else if (to_expired) begin
              state      <= ERROR;
              rd_req     <= 1'b0;
              boot_error <= 1'b1;
            end
          end else begin
            // One idle cycle between bytes of a word, then request the next address.
            rd_req  <= 1'b1;
            rd_addr <= byte_cnt[7:0];
          end
        end
        WRITE: begin
          if (byte_cnt == LAST_CNT) begin
            if (sum_ok) begin
              state         <= DONE;
              boot_complete <= 1'b1;
            end else begin
              state      <= ERROR;
              boot_error <= 1'b1;
            end
          end else begin
            state   <= REQ;
            rd_req  <= 1'b1;
            rd_addr <= byte_cnt[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_boot_loader.sv
// Directed bench: three loader instances (8, 4 and 256 bytes), table of load vectors plus reset/timeout/idle sequences.
module tb_eeprom_boot_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  logic        boot_start[3] = '{1'b0, 1'b0, 1'b0};
  logic        rd_ack[3];
  logic [7:0]  rd_data[3];
  logic        rd_req[3];
  logic [7:0]  rd_addr[3];
  logic        imem_we[3];
  logic [5:0]  imem_addr[3];
  logic [31:0] imem_wdata[3];
  logic        boot_complete[3];
  logic        boot_error[3];

  eeprom_boot_loader #(.NUM_BYTES(8), .TIMEOUT_CYCLES(10)) u_a (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start[0]), .rd_req(rd_req[0]),
    .rd_addr(rd_addr[0]), .rd_ack(rd_ack[0]), .rd_data(rd_data[0]), .imem_we(imem_we[0]),
    .imem_addr(imem_addr[0]), .imem_wdata(imem_wdata[0]),
    .boot_complete(boot_complete[0]), .boot_error(boot_error[0]));

  eeprom_boot_loader #(.NUM_BYTES(4), .TIMEOUT_CYCLES(20)) u_b (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start[1]), .rd_req(rd_req[1]),
    .rd_addr(rd_addr[1]), .rd_ack(rd_ack[1]), .rd_data(rd_data[1]), .imem_we(imem_we[1]),
    .imem_addr(imem_addr[1]), .imem_wdata(imem_wdata[1]),
    .boot_complete(boot_complete[1]), .boot_error(boot_error[1]));

  eeprom_boot_loader #(.NUM_BYTES(256)) u_c (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start[2]), .rd_req(rd_req[2]),
    .rd_addr(rd_addr[2]), .rd_ack(rd_ack[2]), .rd_data(rd_data[2]), .imem_we(imem_we[2]),
    .imem_addr(imem_addr[2]), .imem_wdata(imem_wdata[2]),
    .boot_complete(boot_complete[2]), .boot_error(boot_error[2]));

  typedef struct {
    int          k;
    logic [5:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;

  typedef struct {
    int          k;
    int          dly;
    logic [7:0]  seed;
    logic [7:0]  step;
    logic [7:0]  last;
    int          mid;
    int          exp_n;
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  logic [7:0] img[3][256];
  int   ack_dly[3]  = '{-1, -1, -1};
  logic spur[3]     = '{1'b0, 1'b0, 1'b0};
  int   wcnt[3]     = '{0, 0, 0};
  int   flag_cyc[3] = '{-1, -1, -1};
  logic prev_flag[3] = '{1'b0, 1'b0, 1'b0};
  wr_t  wq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[6];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // EEPROM model: acks the dly-th cycle of each request; spur forces an unsolicited ack.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rd_ack[k]  = spur[k];
      rd_data[k] = spur[k] ? 8'hEE : 8'h00;
      if (rd_req[k] === 1'b1 && ack_dly[k] > 0) begin
        wcnt[k]++;
        if (wcnt[k] == ack_dly[k]) begin
          rd_ack[k]  = 1'b1;
          rd_data[k] = img[k][rd_addr[k]];
          wcnt[k]    = 0;
        end
      end else begin
        wcnt[k] = 0;
      end
    end
  end

  initial forever begin
    wr_t  w;
    logic f;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (imem_we[k] === 1'b1) begin
        w.k = k;
        w.a = imem_addr[k];
        w.d = imem_wdata[k];
        w.c = cyc;
        wq.push_back(w);
      end
      f = (boot_complete[k] === 1'b1) || (boot_error[k] === 1'b1);
      if (f && !prev_flag[k]) flag_cyc[k] = cyc;
      prev_flag[k] = f;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   k;
    int   nb;
    logic finished;
    logic ed;
    logic ee;
    logic [31:0] ew;
    k  = v.k;
    nb = (k == 0) ? 8 : (k == 1) ? 4 : 256;
    for (int i = 0; i < nb; i++) img[k][i] = v.seed + 8'(i) * v.step;
    img[k][nb-1] = v.last;
    ed = v.exp_done;
    ee = v.exp_err;
`ifdef BOOT_CHECKSUM_EN
    begin
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < nb; i++) s = s + img[k][i];
      if (s != 8'h00) begin
        ed = 1'b0;
        ee = 1'b1;
      end
    end
`endif
    ack_dly[k]  = v.dly;
    flag_cyc[k] = -1;
    wq.delete();
    finished = 1'b0;
    @(negedge clk);
    boot_start[k] = 1'b1;
    @(negedge clk);
    boot_start[k] = 1'b0;
    chk($sformatf("v%0d_first_req", idx), {rd_req[k], rd_addr[k], boot_complete[k], boot_error[k]},
        {1'b1, 8'h00, 1'b0, 1'b0});
    for (int i = 1; i <= 4000 && !finished; i++) begin
      @(negedge clk);
      boot_start[k] = (i == v.mid);
      if (boot_complete[k] || boot_error[k]) finished = 1'b1;
    end
    boot_start[k] = 1'b0;
    chk($sformatf("v%0d_finished", idx), finished, 1'b1);
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_nwrites", idx), wq.size(), v.exp_n);
    for (int j = 0; j < wq.size(); j++) begin
      ew = {img[k][4*j+3], img[k][4*j+2], img[k][4*j+1], img[k][4*j]};
      chk($sformatf("v%0d_wr%0d", idx, j), {8'(wq[j].k), wq[j].a, wq[j].d}, {8'(k), 6'(j), ew});
    end
    if (wq.size() > 0) begin
      chk($sformatf("v%0d_last_wr", idx), {wq[wq.size()-1].a, wq[wq.size()-1].d}, {v.exp_addr, v.exp_data});
      chk($sformatf("v%0d_flag_lat", idx), 64'(flag_cyc[k] - wq[wq.size()-1].c), 64'd1);
    end
    chk($sformatf("v%0d_flags", idx), {boot_complete[k], boot_error[k], rd_req[k]}, {ed, ee, 1'b0});
    ack_dly[k] = -1;
  endtask

  initial begin
    int   n;
    logic hit;
    tbl[0] = '{0, 3,  8'h01, 8'h01, 8'h08, 0, 2,  6'd1,  32'h08070605, 1'b1, 1'b0};
    tbl[1] = '{0, 10, 8'h11, 8'h11, 8'h88, 0, 2,  6'd1,  32'h88776655, 1'b1, 1'b0};
    tbl[2] = '{0, 1,  8'hF0, 8'h01, 8'hF7, 9, 2,  6'd1,  32'hF7F6F5F4, 1'b1, 1'b0};
    tbl[3] = '{1, 2,  8'h10, 8'h10, 8'hA0, 0, 1,  6'd0,  32'hA0302010, 1'b1, 1'b0};
    tbl[4] = '{1, 2,  8'h10, 8'h10, 8'hA1, 0, 1,  6'd0,  32'hA1302010, 1'b1, 1'b0};
    tbl[5] = '{2, 1,  8'h00, 8'h01, 8'hFF, 0, 64, 6'd63, 32'hFFFEFDFC, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_k%0d", k), {rd_req[k], rd_addr[k], imem_we[k], imem_addr[k], imem_wdata[k],
          boot_complete[k], boot_error[k]}, 64'd0);

    // Unsolicited acks while idle must not start anything.
    wq.delete();
    #1 spur[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1 spur[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ack", {rd_req[0], boot_complete[0], boot_error[0], 8'(wq.size())}, 64'd0);

    // Timeout: no ack at all.
    ack_dly[0] = -1;
    wq.delete();
    @(negedge clk);
    boot_start[0] = 1'b1;
    @(negedge clk);
    boot_start[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && boot_error[0] !== 1'b1; i++) begin
      if (rd_req[0]) n++;
      @(negedge clk);
    end
    chk("to_req_cycles", n, 10);
    chk("to_flags", {boot_error[0], boot_complete[0], rd_req[0]}, 3'b100);
    repeat (3) @(negedge clk);
    chk("to_no_write", wq.size(), 0);

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // Asynchronous reset after two bytes of the first word, then a clean reload.
    for (int i = 0; i < 8; i++) img[0][i] = 8'(i + 1);
    ack_dly[0] = 3;
    wq.delete();
    @(negedge clk);
    boot_start[0] = 1'b1;
    @(negedge clk);
    boot_start[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (rd_req[0] && rd_addr[0] == 8'd2) hit = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reached_byte2", hit, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_zero", {rd_req[0], rd_addr[0], imem_we[0], imem_wdata[0], boot_complete[0], boot_error[0]}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_partial_write", {rd_req[0], 8'(wq.size())}, 64'd0);
    run_vec(6, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eeprom_boot_loader.md
EEPROM_BOOT_LOADER -- requirements
Module: eeprom_boot_loader

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_BYTES, 256, image length in bytes, multiple of 4, at most 256.
REQ-002 TIMEOUT_CYCLES, 65535, maximum cycles to wait for rd_ack per byte.
REQ-003 Ports SHALL be: clk  in  1  single system clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 boot_start  in  1  one-cycle pulse that starts image load.
REQ-006 rd_req  out  1  byte read request to the EEPROM controller.
REQ-007 rd_addr  out  8  EEPROM byte address of the current request.
REQ-008 rd_ack  in  1  one-cycle pulse; rd_data valid in the same cycle.
REQ-009 rd_data  in  8  byte returned by the EEPROM controller.
REQ-010 imem_we  out  1  instruction-memory write strobe, one cycle.
REQ-011 imem_addr  out  6  instruction-memory word address.
REQ-012 imem_wdata  out  32  word to write.
REQ-013 boot_complete  out  1  image loaded without error; sticky.
REQ-014 boot_error  out  1  timeout or checksum failure; sticky.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WRITE, DONE and ERROR.
REQ-016 IDLE: boot_start moves to REQ on the next edge, clears byte_cnt, the word buffer, checksum, boot_complete and boot_error.
REQ-017 REQ: rd_req=1 and rd_addr=byte_cnt, held constant until rd_ack.
REQ-018 REQ, rd_ack=1: rd_data stored in word-buffer lane byte_cnt[1:0] (little-endian, byte 0 in bits 7:0); byte_cnt increments; rd_req is 0 on the following cycle.
REQ-019 REQ, rd_ack with byte_cnt[1:0]==3: next state WRITE; otherwise remain in REQ and re-request at the next address after exactly one idle cycle.
REQ-020 WRITE: imem_we=1 for one cycle; imem_addr=(byte_cnt-1)>>2; imem_wdata=assembled word.
REQ-021 WRITE: goes to DONE after the word containing byte NUM_BYTES-1, else to REQ.
REQ-022 Latency: boot_start to first rd_req is 1 cycle; last rd_ack to its imem_we is 1 cycle; that imem_we to boot_complete is 1 cycle.
REQ-023 Timeout: a 16-bit counter SHALL clear on entry to REQ and count each REQ cycle without rd_ack; on reaching TIMEOUT_CYCLES go to ERROR.
REQ-024 ERROR: boot_error=1, rd_req=0, imem_we=0.
REQ-025 DONE: boot_complete=1, rd_req=0.
REQ-026 boot_start SHALL be ignored in REQ and WRITE.
REQ-027 In DONE and ERROR, boot_start SHALL restart as from IDLE.
REQ-028 rd_ack outside REQ SHALL be ignored.
REQ-029 rd_ack in the same cycle as timeout expiry SHALL win: the byte is accepted and there is no error.
REQ-030 byte_cnt SHALL be 9 bits so NUM_BYTES=256 does not wrap before the DONE decision.

Reset
REQ-031 rst_n low SHALL force IDLE and zero all outputs, counters and buffers immediately, including mid-transfer.
REQ-032 After reset, no imem_we SHALL be issued for a partially assembled word.

Configuration
REQ-033 Macro BOOT_CHECKSUM_EN defined: an 8-bit running sum of all accepted bytes SHALL be kept.
REQ-034 With BOOT_CHECKSUM_EN, the final WRITE goes to DONE only if the sum mod 256 is 0x00, else to ERROR.
REQ-035 BOOT_CHECKSUM_EN undefined: no checksum logic; the final WRITE always goes to DONE.

Structure
REQ-036 Package boot_pkg SHALL hold the FSM state enum and the default constants for NUM_BYTES and TIMEOUT_CYCLES.
REQ-037 The timeout counter SHALL be sub-module boot_timeout (clear, enable, expired); there is no other sub-module.

Verification
REQ-038 Test 1: NUM_BYTES=8, bytes 0x01..0x08, rd_ack 3 cycles after each rd_req -> imem writes addr0=0x04030201 and addr1=0x08070605; boot_complete rises 1 cycle after the second write.
REQ-039 Test 2: TIMEOUT_CYCLES=10, rd_ack never given -> boot_error=1 at the 10th REQ cycle; rd_req falls; no imem_we.
REQ-040 Test 3: BOOT_CHECKSUM_EN, bytes 0x10,0x20,0x30,0xA0 (sum 0x00) -> DONE; last byte changed to 0xA1 -> ERROR after the single write.
REQ-041 Test 4: rst_n low after byte 2 of a word -> outputs 0 asynchronously; a new boot_start reloads from address 0.
REQ-042 Test 5: boot_start pulsed mid-load and rd_ack pulsed in IDLE -> both ignored; write sequence unchanged.
REQ-043 Test 6: NUM_BYTES=256 full load -> 64 writes, last imem_addr=63, boot_complete=1.
